// File: rtl/minibus_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : minibus_arbiter_if
// Brief    : Upstream master bundle plus downstream minibus port of the arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface minibus_arbiter_if #(
   parameter int MASTER_COUNT = 2
);
   logic [MASTER_COUNT*32-1:0] m_addr;
   logic [MASTER_COUNT*32-1:0] m_wdata;
   logic [MASTER_COUNT-1:0]    m_ren;
   logic [MASTER_COUNT-1:0]    m_wen;
   logic [MASTER_COUNT*32-1:0] m_rdata;
   logic [MASTER_COUNT-1:0]    m_ready;
   logic [MASTER_COUNT-1:0]    m_err;
   logic [31:0]                s_addr;
   logic [31:0]                s_wdata;
   logic                       s_ren;
   logic                       s_wen;
   logic [31:0]                s_rdata;
   logic                       s_ready;

   // Arbiter side: serves the upstream masters and drives the downstream bus.
   modport slave (
      input  m_addr, m_wdata, m_ren, m_wen, s_rdata, s_ready,
      output m_rdata, m_ready, m_err, s_addr, s_wdata, s_ren, s_wen
   );

   // Environment side: the upstream masters together with the downstream slave.
   modport master (
      output m_addr, m_wdata, m_ren, m_wen, s_rdata, s_ready,
      input  m_rdata, m_ready, m_err, s_addr, s_wdata, s_ren, s_wen
   );
endinterface

`default_nettype wire

// File: rtl/minibus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : minibus_arbiter
// Brief    : Round-robin N-to-1 minibus arbiter with per-transaction watchdog.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module minibus_arbiter #(
   parameter int          MASTER_COUNT   = 2,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
   input  wire logic          clk,
   input  wire logic          nrst,
   minibus_arbiter_if.slave   bus
);
   localparam int c_idx_w = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
   localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(MASTER_COUNT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_idx_w-1:0]   r_grant;
   logic [c_idx_w-1:0]   w_grant_nxt;
   logic [c_idx_w-1:0]   r_rr;
   logic [c_idx_w-1:0]   w_rr_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_cnt_w-1:0]   w_cnt_nxt;

   logic [MASTER_COUNT-1:0] w_req;
   logic                    w_found;
   logic [c_idx_w-1:0]      w_pick;
   logic                    w_g_req;
   logic                    w_timeout;

   assign w_req   = bus.m_ren | bus.m_wen;
   assign w_g_req = w_req[r_grant];

   // First requester at or above the rr pointer, wrapping modulo MASTER_COUNT.
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_pick  = r_rr;
      for (int k = 0; k < MASTER_COUNT; k++) begin
         idx = int'(r_rr) + k;
         if (idx >= MASTER_COUNT) begin
            idx = idx - MASTER_COUNT;
         end
         if (!w_found && w_req[idx]) begin
            w_found = 1'b1;
            w_pick  = c_idx_w'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_rr    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_rr    <= w_rr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rr_nxt     = r_rr;
      w_cnt_nxt    = r_cnt;
      w_timeout    = 1'b0;
      bus.s_addr   = '0;
      bus.s_wdata  = '0;
      bus.s_ren    = 1'b0;
      bus.s_wen    = 1'b0;
      bus.m_rdata  = '0;
      bus.m_ready  = '0;
      bus.m_err    = '0;

      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (w_found) begin
               w_grant_nxt = w_pick;
               w_state_nxt = GRANT;
            end
         end

         GRANT: begin
            w_timeout   = (r_cnt == c_cnt_last) && !bus.s_ready;
            w_cnt_nxt   = r_cnt + 1'b1;
            bus.s_addr  = bus.m_addr[int'(r_grant)*32 +: 32];
            bus.s_wdata = bus.m_wdata[int'(r_grant)*32 +: 32];
            bus.s_ren   = bus.m_ren[r_grant] && !w_timeout;
            bus.s_wen   = bus.m_wen[r_grant] && !w_timeout;

            // A dropped request abandons the transfer silently, even if the
            // slave or the watchdog would complete it this cycle.
            if (!w_g_req) begin
               w_state_nxt = IDLE;
            end else if (bus.s_ready || w_timeout) begin
               bus.m_ready[r_grant] = 1'b1;
               bus.m_err[r_grant]   = w_timeout;
               bus.m_rdata[int'(r_grant)*32 +: 32] = w_timeout ? ERR_RDATA : bus.s_rdata;
               w_state_nxt = IDLE;
               w_rr_nxt    = (r_grant == c_last_idx) ? '0 : r_grant + 1'b1;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end
endmodule

`default_nettype wire

// File: tb/tb_minibus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_minibus_arbiter
// Brief    : Directed self-checking bench for minibus_arbiter (2 masters, 8-cycle watchdog).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_minibus_arbiter;
   localparam int c_n  = 2;
   localparam int c_to = 8;

   logic clk;
   logic nrst;
   int   n_checks;
   int   n_errors;

   minibus_arbiter_if #(.MASTER_COUNT(c_n)) bus ();

   minibus_arbiter #(
      .MASTER_COUNT  (c_n),
      .TIMEOUT_CYCLES(c_to),
      .ERR_RDATA     (32'hDEADBEEF)
   ) dut (
      .clk (clk),
      .nrst(nrst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp_g [4];

   initial begin
      n_checks = 0;
      n_errors = 0;
      nrst        = 1'b0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.m_ren   = '0;
      bus.m_wen   = '0;
      bus.s_rdata = '0;
      bus.s_ready = 1'b0;
      #2;
      chk("reset_s_ren",   {63'd0, bus.s_ren},   64'd0);
      chk("reset_s_addr",  {32'd0, bus.s_addr},  64'd0);
      chk("reset_m_ready", {62'd0, bus.m_ready}, 64'd0);
      tick();
      tick();
      nrst = 1'b1;

      // Single read by master 0, slave answers on the third GRANT cycle
      tick();
      bus.m_ren  = 2'b01;
      bus.m_addr = {32'h0, 32'h10};
      #1;
      chk("rd_idle_s_ren", {63'd0, bus.s_ren}, 64'd0);
      tick();
      #1;
      chk("rd_grant_s_ren",  {63'd0, bus.s_ren},  64'd1);
      chk("rd_grant_s_addr", {32'd0, bus.s_addr}, 64'h10);
      chk("rd_wait_ready",   {62'd0, bus.m_ready}, 64'd0);
      tick();
      #1;
      chk("rd_wait2_ready",  {62'd0, bus.m_ready}, 64'd0);
      tick();
      bus.s_ready = 1'b1;
      bus.s_rdata = 32'h12345678;
      #1;
      chk("rd_m_ready", {62'd0, bus.m_ready}, 64'd1);
      chk("rd_m_err",   {62'd0, bus.m_err},   64'd0);
      chk("rd_m_rdata", bus.m_rdata, 64'h00000000_12345678);
      tick();
      bus.m_ren   = 2'b00;
      bus.s_ready = 1'b0;
      #1;
      chk("rd_after_s_ren",   {63'd0, bus.s_ren},   64'd0);
      chk("rd_after_m_ready", {62'd0, bus.m_ready}, 64'd0);

      // Contention: rr pointer sits at 1 after master 0 completed
      exp_g[0] = 2'd1;
      exp_g[1] = 2'd0;
      exp_g[2] = 2'd1;
      exp_g[3] = 2'd0;
      bus.m_wen   = 2'b11;
      bus.m_addr  = {32'h200, 32'h100};
      bus.m_wdata = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
      bus.s_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         #1;
         chk("cont_idle_s_wen", {63'd0, bus.s_wen}, 64'd0);
         tick();
         #1;
         chk("cont_s_wen",   {63'd0, bus.s_wen}, 64'd1);
         chk("cont_s_addr",  {32'd0, bus.s_addr},
             (exp_g[t] == 2'd1) ? 64'h200 : 64'h100);
         chk("cont_s_wdata", {32'd0, bus.s_wdata},
             (exp_g[t] == 2'd1) ? 64'hBBBB_BBBB : 64'hAAAA_AAAA);
         chk("cont_m_ready", {62'd0, bus.m_ready},
             (exp_g[t] == 2'd1) ? 64'd2 : 64'd1);
         tick();
      end
      bus.m_wen   = 2'b00;
      bus.s_ready = 1'b0;

      // Timeout on master 1 (rr back at 1), slave never responds
      tick();
      bus.m_ren  = 2'b10;
      bus.m_addr = {32'h5000, 32'h0};
      tick();
      for (int c = 0; c < c_to - 1; c++) begin
         #1;
         chk("to_wait_s_ren",   {63'd0, bus.s_ren},   64'd1);
         chk("to_wait_m_ready", {62'd0, bus.m_ready}, 64'd0);
         tick();
      end
      #1;
      chk("to_m_ready", {62'd0, bus.m_ready}, 64'd2);
      chk("to_m_err",   {62'd0, bus.m_err},   64'd2);
      chk("to_m_rdata", bus.m_rdata, 64'hDEADBEEF_00000000);
      chk("to_s_ren",   {63'd0, bus.s_ren},   64'd0);
      tick();
      bus.m_ren = 2'b00;
      #1;
      chk("to_after_ready", {62'd0, bus.m_ready}, 64'd0);

      // Abort: master 0 drops its write mid-GRANT; rr pointer is now 0
      tick();
      bus.m_wen  = 2'b01;
      bus.m_addr = {32'h0, 32'h300};
      tick();
      #1;
      chk("ab_s_wen_on", {63'd0, bus.s_wen}, 64'd1);
      tick();
      bus.m_wen = 2'b00;
      #1;
      chk("ab_s_wen_off", {63'd0, bus.s_wen},   64'd0);
      chk("ab_m_ready",   {62'd0, bus.m_ready}, 64'd0);
      tick();
      bus.m_ren  = 2'b11;
      bus.m_addr = {32'h700, 32'h600};
      #1;
      chk("ab_idle_s_ren", {63'd0, bus.s_ren},   64'd0);
      chk("ab_idle_ready", {62'd0, bus.m_ready}, 64'd0);
      tick();
      bus.s_ready = 1'b1;
      bus.s_rdata = 32'h0000_0600;
      #1;
      chk("ab_regrant_addr",  {32'd0, bus.s_addr},  64'h600);
      chk("ab_regrant_ready", {62'd0, bus.m_ready}, 64'd1);
      tick();
      bus.m_ren   = 2'b10;
      bus.s_ready = 1'b0;

      // Reset while master 1 is granted
      tick();
      #1;
      chk("rst_pre_s_ren",  {63'd0, bus.s_ren},  64'd1);
      chk("rst_pre_s_addr", {32'd0, bus.s_addr}, 64'h700);
      nrst = 1'b0;
      #1;
      chk("rst_s_ren",   {63'd0, bus.s_ren},   64'd0);
      chk("rst_s_addr",  {32'd0, bus.s_addr},  64'd0);
      chk("rst_m_ready", {62'd0, bus.m_ready}, 64'd0);
      bus.m_ren = 2'b11;
      tick();
      nrst = 1'b1;
      tick();
      bus.s_ready = 1'b1;
      bus.s_rdata = 32'h0000_ABCD;
      #1;
      chk("rst_first_addr",  {32'd0, bus.s_addr},  64'h600);
      chk("rst_first_ready", {62'd0, bus.m_ready}, 64'd1);
      chk("rst_first_rdata", bus.m_rdata, 64'h00000000_0000ABCD);
      tick();
      bus.m_ren   = 2'b10;
      bus.s_ready = 1'b0;

      // Late ready exactly on the watchdog cycle
      tick();
      for (int c = 0; c < c_to - 1; c++) begin
         #1;
         chk("late_wait_ready", {62'd0, bus.m_ready}, 64'd0);
         tick();
      end
      bus.s_ready = 1'b1;
      bus.s_rdata = 32'hCAFE_F00D;
      #1;
      chk("late_m_ready", {62'd0, bus.m_ready}, 64'd2);
      chk("late_m_err",   {62'd0, bus.m_err},   64'd0);
      chk("late_m_rdata", bus.m_rdata, 64'hCAFEF00D_00000000);
      chk("late_s_ren",   {63'd0, bus.s_ren},   64'd1);
      tick();
      bus.m_ren   = 2'b00;
      bus.s_ready = 1'b0;
      #1;
      chk("late_after_s_ren", {63'd0, bus.s_ren}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire
